clk_div_gen: RTL and testbench

//  Multi-channel programmable divider fed by the on-chip oscillator clock (OSC_CLK output).
//  Per channel: 1-cycle tick (clock-enable for UART/timer/display logic) and registered divided clk_out.

---
 rtl/clkdiv_pkg.sv | 22 ++
 rtl/clkdiv_channel.sv | 79 +++++++
 rtl/clk_div_gen.sv | 76 +++++++
 tb/tb_clk_div_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared defaults, per-edge channel action encoding and the clk_out threshold rule
// for the clk_div_gen programmable divider.
package clkdiv_pkg;

  localparam int NCH_DEF     = 4;
  localparam int DIV_W_DEF   = 16;
  localparam int DEF_DIV_DEF = 1;

  // Action a channel takes on the coming clock edge, highest priority first.
  typedef enum logic [1:0] {
    CH_SYNC   = 2'd0,
    CH_OFF    = 2'd1,
    CH_RELOAD = 2'd2,
    CH_COUNT  = 2'd3
  } ch_op_e;

  // clk_out is high while the down-counter sits above half the divisor (DIV_W <= 32).
  function automatic logic [31:0] clk_thresh(input logic [31:0] d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: down-counter, active divisor and a pending divisor that is
// only adopted at terminal count, while disabled, or on a phase-align request.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pending,
  output logic             tick,
  output logic             clk_out
);

  ch_op_e           op;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] reload_div;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] active_nxt;
  logic [DIV_W-1:0] thresh;
  logic             run;

  always_comb begin
    if (sync)            op = CH_SYNC;
    else if (!en)        op = CH_OFF;
    else if (cnt == '0)  op = CH_RELOAD;
    else                 op = CH_COUNT;
  end

  assign reload_div = pending ? pend_div : active;

  always_comb begin
    cnt_nxt    = '0;
    active_nxt = active;
    unique case (op)
      CH_SYNC, CH_OFF: active_nxt = reload_div;
      CH_RELOAD: begin
        cnt_nxt    = reload_div;
        active_nxt = reload_div;
      end
      CH_COUNT:        cnt_nxt = cnt - 1'b1;
      default: ;
    endcase
  end

  assign run    = (op == CH_RELOAD) || (op == CH_COUNT);
  assign thresh = DIV_W'(clk_thresh(32'(active_nxt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      active   <= DIV_W'(DEF_DIV);
      pend_div <= '0;
      pending  <= 1'b0;
      tick     <= 1'b0;
      clk_out  <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      active  <= active_nxt;
      tick    <= (op == CH_RELOAD);
      clk_out <= run && (cnt_nxt > thresh);
      // A write landing on an apply edge stays pending: the apply used the old value.
      if (wr) begin
        pend_div <= wr_div;
        pending  <= 1'b1;
      end else if (op != CH_COUNT) begin
        pending  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with glitch-free divisor updates.
// Optional CLKDIV_SYNC_EN adds the sync_all input for phase-aligning every channel.
module clk_div_gen
  import clkdiv_pkg::*;
#(
  parameter  int NCH     = NCH_DEF,
  parameter  int DIV_W   = DIV_W_DEF,
  parameter  int DEF_DIV = DEF_DIV_DEF,
  localparam int CH_W    = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   ch_en,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_div,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_all,
`endif
  output logic             wr_ack,
  output logic             wr_err,
  output logic [NCH-1:0]   pending,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_out
);

  localparam logic [CH_W:0] NCH_L = (CH_W + 1)'(NCH);

  logic           wr_ok;
  logic [NCH-1:0] wr_sel;
  logic           sync_int;

`ifdef CLKDIV_SYNC_EN
  assign sync_int = sync_all;
`else
  assign sync_int = 1'b0;
`endif

  // Channel indices past NCH are representable when NCH is not a power of two.
  assign wr_ok = wr_en && ({1'b0, wr_ch} < NCH_L);

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_sel[i] = wr_ok && (wr_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= wr_ok;
      wr_err <= wr_en && !wr_ok;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clkdiv_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (ch_en[g]),
      .sync    (sync_int),
      .wr      (wr_sel[g]),
      .wr_div  (wr_div),
      .pending (pending[g]),
      .tick    (tick[g]),
      .clk_out (clk_out[g])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: a period/phase reference model predicts every
// cycle's outputs, a monitor pops and compares them after each rising edge.
module tb_clk_div_gen;

  localparam int NCH     = 3;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 1;
  localparam int CH_W    = $clog2(NCH);
  localparam int EW      = 3 * NCH + 2;

  logic             clk;
  logic             rst;
  logic [NCH-1:0]   ch_en;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [DIV_W-1:0] wr_div;
`ifdef CLKDIV_SYNC_EN
  logic             sync_all;
`endif
  logic             wr_ack;
  logic             wr_err;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   clk_out;

  clk_div_gen #(
    .NCH     (NCH),
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_en    (ch_en),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
`ifdef CLKDIV_SYNC_EN
    .sync_all (sync_all),
`endif
    .wr_ack   (wr_ack),
    .wr_err   (wr_err),
    .pending  (pending),
    .tick     (tick),
    .clk_out  (clk_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // reference model: each channel is "position within the current period"
  int m_active[NCH];
  int m_pend[NCH];
  int m_pos[NCH];
  bit m_pending[NCH];
  bit m_running[NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_active[c]  = DEF_DIV;
      m_pend[c]    = 0;
      m_pos[c]     = 0;
      m_pending[c] = 1'b0;
      m_running[c] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [NCH-1:0] en, input bit wr, input int wch,
                            input int wdiv, input bit sync, output logic [EW-1:0] e);
    logic [NCH-1:0] t;
    logic [NCH-1:0] o;
    logic [NCH-1:0] p;
    bit ok;
    for (int c = 0; c < NCH; c++) begin
      t[c] = 1'b0;
      o[c] = 1'b0;
      if (sync || !en[c]) begin
        m_running[c] = 1'b0;
        if (m_pending[c]) m_active[c] = m_pend[c];
        m_pending[c] = 1'b0;
      end else begin
        if (!m_running[c] || m_pos[c] == m_active[c]) begin
          if (m_pending[c]) m_active[c] = m_pend[c];
          m_pending[c] = 1'b0;
          m_pos[c]     = 0;
          m_running[c] = 1'b1;
          t[c]         = 1'b1;
        end else begin
          m_pos[c]++;
        end
        // a period of D+1 cycles is high for its first ceil(D/2) cycles
        o[c] = (m_pos[c] < (m_active[c] + 1) / 2);
      end
    end
    ok = wr && (wch < NCH);
    if (ok) begin
      m_pend[wch]    = wdiv;
      m_pending[wch] = 1'b1;
    end
    for (int c = 0; c < NCH; c++) p[c] = m_pending[c];
    e = {ok, wr && !ok, p, t, o};
  endtask

  // driver: apply inputs now and queue the response of the next rising edge
  task automatic apply(input logic [NCH-1:0] en, input bit wr, input int wch,
                       input int wdiv, input bit sync);
    logic [EW-1:0] e;
    ch_en  = en;
    wr_en  = wr;
    wr_ch  = wch[CH_W-1:0];
    wr_div = wdiv[DIV_W-1:0];
`ifdef CLKDIV_SYNC_EN
    sync_all = sync;
`endif
    model_step(en, wr, wch, wdiv, sync, e);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [NCH-1:0] en, input bit wr, input int wch,
                       input int wdiv, input bit sync);
    @(negedge clk);
    apply(en, wr, wch, wdiv, sync);
  endtask

  task automatic idle(input logic [NCH-1:0] en, input int n);
    for (int i = 0; i < n; i++) drive(en, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_ack",  32'(wr_ack),  32'(e[EW-1]));
        check("wr_err",  32'(wr_err),  32'(e[EW-2]));
        check("pending", 32'(pending), 32'(e[3*NCH-1:2*NCH]));
        check("tick",    32'(tick),    32'(e[2*NCH-1:NCH]));
        check("clk_out", 32'(clk_out), 32'(e[NCH-1:0]));
      end
    end
  end

  // stimulus
  logic [NCH-1:0] cur_en;
  int             guard;
  bit             rnd_sync;

  initial begin
    rst    = 1'b1;
    ch_en  = '0;
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_div = '0;
`ifdef CLKDIV_SYNC_EN
    sync_all = 1'b0;
`endif
    model_reset();
    #12;
    check("reset_outputs", 32'({wr_ack, wr_err, pending, tick, clk_out}), 32'd0);

    // ch0 alone at the reset divisor
    @(negedge clk);
    rst    = 1'b0;
    cur_en = 3'b001;
    apply(cur_en, 1'b0, 0, 0, 1'b0);
    idle(cur_en, 8);

    // ch1 running D=1, retuned to D=4
    cur_en = 3'b011;
    idle(cur_en, 3);
    drive(cur_en, 1'b1, 1, 4, 1'b0);
    idle(cur_en, 14);

    // ch2 to D=0
    cur_en = 3'b111;
    drive(cur_en, 1'b1, 2, 0, 1'b0);
    idle(cur_en, 8);

    // out-of-range channel
    drive(cur_en, 1'b1, NCH, 5, 1'b0);
    idle(cur_en, 4);

    // write landing exactly on ch0's terminal count
    drive(cur_en, 1'b1, 0, 3, 1'b0);
    idle(cur_en, 9);
    guard = 0;
    while (!(m_running[0] && m_pos[0] == m_active[0]) && guard < 20) begin
      drive(cur_en, 1'b0, 0, 0, 1'b0);
      guard++;
    end
    check("tc_align_found", 32'(guard < 20), 32'd1);
    drive(cur_en, 1'b1, 0, 6, 1'b0);
    idle(cur_en, 20);

    // two writes before apply: last wins; then disable with a divisor pending
    drive(cur_en, 1'b1, 1, 2, 1'b0);
    drive(cur_en, 1'b1, 1, 5, 1'b0);
    idle(cur_en, 3);
    drive(cur_en, 1'b1, 2, 3, 1'b0);
    cur_en = 3'b011;
    idle(cur_en, 3);
    cur_en = 3'b111;
    idle(cur_en, 10);

`ifdef CLKDIV_SYNC_EN
    // phase alignment of ch0 D=3 and ch1 D=7
    drive(cur_en, 1'b1, 0, 3, 1'b0);
    idle(cur_en, 5);
    drive(cur_en, 1'b1, 1, 7, 1'b0);
    idle(cur_en, 3);
    drive(cur_en, 1'b0, 0, 0, 1'b1);
    idle(cur_en, 20);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(15) == 0) cur_en[c] = ~cur_en[c];
      rnd_sync = 1'b0;
`ifdef CLKDIV_SYNC_EN
      rnd_sync = ($urandom_range(31) == 0);
`endif
      drive(cur_en, ($urandom_range(3) == 0), $urandom_range(3), $urandom_range(9), rnd_sync);
    end

    // asynchronous reset in mid-period
    cur_en = 3'b111;
    drive(cur_en, 1'b1, 0, 6, 1'b0);
    idle(cur_en, 4);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", 32'({wr_ack, wr_err, pending, tick, clk_out}), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(cur_en, 1'b0, 0, 0, 1'b0);
    idle(cur_en, 10);

    idle(cur_en, 1);
    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
